// File: rtl/mux_arb_n_to_1.sv
// N-to-1 registered arbiter/mux: fixed priority or round-robin grant; MUX_ARB_LOCK_EN adds a `lock` port that pins the grant to one channel.
// Latency 1 cycle (input transfer at edge k is visible on out_* after edge k), 1 word/cycle sustained.
// Backpressure: while out_valid & ~out_ready, in_ready is all zero and the output register holds.
module mux_arb_n_to_1 #(
  parameter int N = 32,
  parameter int W = 32,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic           lock
`endif
);

  logic [W-1:0]  ch [N];
  logic [N-1:0]  elig;
  logic [N-1:0]  req;
  logic [SW-1:0] ptr;
  logic [SW-1:0] g;
  logic [SW-1:0] ptr_nxt;
  logic          found;
  logic          adv;
  int            idx;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch[i] = in_data[i*W +: W];
  end

`ifdef MUX_ARB_LOCK_EN
  logic          lock_flag;
  logic [SW-1:0] lock_idx;

  // A held lock masks every other channel, even when the owner is idle.
  always_comb begin
    elig = '0;
    if (lock_flag) elig[lock_idx] = 1'b1;
    else           elig = '1;
  end
`else
  assign elig = '1;
`endif

  assign req = in_valid & elig;
  assign adv = ~out_valid | out_ready;

  // Scan order starts at ptr in round-robin mode, at 0 in fixed mode.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      if (mode) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
      end else begin
        idx = k;
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        g     = SW'(idx);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && adv && found) in_ready[g] = 1'b1;
  end

  assign ptr_nxt = (g == SW'(N-1)) ? '0 : g + SW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef MUX_ARB_LOCK_EN
      lock_flag <= 1'b0;
      lock_idx  <= '0;
`endif
    end else if (adv) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= ch[g];
        out_sel   <= g;
        ptr       <= ptr_nxt;
`ifdef MUX_ARB_LOCK_EN
        lock_flag <= lock;
        lock_idx  <= g;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_n_to_1.sv
// Bench for mux_arb_n_to_1: an N=4 and an N=5 instance run side by side against a behavioural model.
module tb_mux_arb_n_to_1;

`ifdef MUX_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        out_ready;
  logic        lock;
  logic [3:0]  iv4;
  logic [31:0] id4;
  logic [3:0]  rdy4;
  logic        ov4;
  logic [7:0]  od4;
  logic [1:0]  os4;
  logic [4:0]  iv5;
  logic [39:0] id5;
  logic [4:0]  rdy5;
  logic        ov5;
  logic [7:0]  od5;
  logic [2:0]  os5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_arb_n_to_1 #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(iv4), .in_data(id4),
    .in_ready(rdy4), .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(out_ready)
`ifdef MUX_ARB_LOCK_EN
    , .lock(lock)
`endif
  );

  mux_arb_n_to_1 #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(iv5), .in_data(id5),
    .in_ready(rdy5), .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(out_ready)
`ifdef MUX_ARB_LOCK_EN
    , .lock(lock)
`endif
  );

  // Reference state per instance (0: N=4, 1: N=5), kept as plain integers.
  int         m_ptr [2];
  bit         m_v   [2];
  logic [7:0] m_d   [2];
  int         m_s   [2];
  bit         m_lk  [2];
  int         m_li  [2];
  int         m_g   [2];   // channel transferred on the last edge, -1 if none

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input int inst, input logic [7:0] v);
    int n;
    int i;
    n = (inst == 0) ? 4 : 5;
    for (int k = 0; k < n; k++) begin
      i = mode ? (m_ptr[inst] + k) % n : k;
      if (v[i] && (!m_lk[inst] || m_li[inst] == i)) return i;
    end
    return -1;
  endfunction

  task automatic cycle();
    logic [7:0] v   [2];
    logic [7:0] dat [2];
    int         g   [2];
    bit         adv [2];
    logic [7:0] er;
    bit         rs;
    bit         lk;
    v[0] = {4'b0, iv4};
    v[1] = {3'b0, iv5};
    #1;
    rs = rst_n;
    lk = lock;
    for (int inst = 0; inst < 2; inst++) begin
      adv[inst] = !m_v[inst] || out_ready;
      g[inst]   = model_grant(inst, v[inst]);
      er = '0;
      if (rs && adv[inst] && g[inst] >= 0) er[g[inst]] = 1'b1;
      dat[inst] = (g[inst] < 0) ? 8'h00 : (inst == 0 ? id4[g[inst]*8 +: 8] : id5[g[inst]*8 +: 8]);
      if (inst == 0) check("in_ready4", {28'b0, rdy4}, {24'b0, er});
      else           check("in_ready5", {27'b0, rdy5}, {24'b0, er});
    end
    @(posedge clk);
    for (int inst = 0; inst < 2; inst++) begin
      m_g[inst] = -1;
      if (!rs) begin
        m_v[inst] = 0; m_d[inst] = 8'h00; m_s[inst] = 0; m_ptr[inst] = 0; m_lk[inst] = 0;
      end else if (adv[inst]) begin
        if (g[inst] >= 0) begin
          m_g[inst]   = g[inst];
          m_v[inst]   = 1;
          m_d[inst]   = dat[inst];
          m_s[inst]   = g[inst];
          m_ptr[inst] = (g[inst] + 1) % (inst == 0 ? 4 : 5);
          m_lk[inst]  = LOCK_EN && lk;
          m_li[inst]  = g[inst];
        end else begin
          m_v[inst] = 0;
        end
      end
    end
    #1;
    check("out_valid4", {31'b0, ov4}, {31'b0, m_v[0]});
    check("out_data4",  {24'b0, od4}, {24'b0, m_d[0]});
    check("out_sel4",   {30'b0, os4}, 32'(m_s[0]));
    check("out_valid5", {31'b0, ov5}, {31'b0, m_v[1]});
    check("out_data5",  {24'b0, od5}, {24'b0, m_d[1]});
    check("out_sel5",   {29'b0, os5}, 32'(m_s[1]));
  endtask

  initial begin
    logic [7:0] held;
    int         guard;
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_v[i] = 0; m_d[i] = 8'h00; m_s[i] = 0; m_lk[i] = 0; m_li[i] = 0; m_g[i] = -1;
    end
    rst_n = 1'b0; mode = 1'b0; out_ready = 1'b1; lock = 1'b0;
    iv4 = 4'b1111; iv5 = 5'b11111;
    id4 = 32'h44332211; id5 = 40'h5544332211;

    // Reset: in_ready must stay low even with every channel requesting.
    cycle(); cycle();
    check("rst_out_valid", {31'b0, ov4}, 32'd0);
    check("rst_out_data",  {24'b0, od4}, 32'd0);
    rst_n = 1'b1; iv5 = '0;

    // Fixed priority, channel 3 starved behind channel 1.
    iv4 = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("fixed_sel1", {30'b0, os4}, 32'd1);
    end

    // Round-robin wrap from a freshly reset pointer.
    rst_n = 1'b0; iv4 = '0; cycle(); rst_n = 1'b1;
    mode = 1'b1; iv4 = 4'b1111; id4 = 32'hA3A2A1A0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_seq", {24'b0, od4}, 32'hA0 + 32'(k % 4));
    end
    iv4 = '0;

    // N=5 pointer wrap: channel 4 then channel 0.
    iv5 = 5'b10000; id5 = 40'h0403020100; cycle();
    check("n5_sel4", {29'b0, os5}, 32'd4);
    iv5 = 5'b00001; cycle();
    check("n5_sel0", {29'b0, os5}, 32'd0);
    iv5 = '0; cycle();

    // Backpressure: full output held for three cycles, then consume and refill.
    mode = 1'b0; id4 = 32'h3C2B1A09; iv4 = 4'b0010; cycle();
    held = od4;
    iv4 = 4'b1111; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_stable", {24'b0, od4}, {24'b0, held});
    end
    out_ready = 1'b1; cycle();
    check("bp_refill", {24'b0, od4}, 32'h09);

    // Reset while holding a word.
    rst_n = 1'b0; cycle();
    check("midrst_valid", {31'b0, ov4}, 32'd0);
    check("midrst_data",  {24'b0, od4}, 32'd0);
    rst_n = 1'b1; iv4 = '0; cycle();

`ifdef MUX_ARB_LOCK_EN
    // Lock pins the grant to channel 2 until it transfers with lock low.
    mode = 1'b1; id4 = 32'h33221100;
    lock = 1'b1; iv4 = 4'b0100; cycle();
    check("lock_first", {30'b0, os4}, 32'd2);
    iv4 = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("lock_hold", {30'b0, os4}, 32'd2);
    end
    lock = 1'b0; cycle();
    check("lock_release", {30'b0, os4}, 32'd2);
    cycle();
    check("lock_next", {30'b0, os4}, 32'd3);
    iv4 = '0; cycle();
`endif

    // Random traffic; producers hold valid/data until their transfer completes.
    iv4 = '0; iv5 = '0;
    guard = 0;
    for (int k = 0; k < 400; k++) begin
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      lock      = LOCK_EN && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!iv4[i] || m_g[0] == i) begin
          iv4[i] = 1'($urandom_range(0, 1));
          id4[i*8 +: 8] = 8'($urandom);
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (!iv5[i] || m_g[1] == i) begin
          iv5[i] = 1'($urandom_range(0, 1));
          id5[i*8 +: 8] = 8'($urandom);
        end
      end
      cycle();
      guard++;
    end
    check("random_cycles", 32'(guard), 32'd400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
